output_display_driver: RTL and testbench
========================================

// Module: output_display_driver
// PURPOSE
//  Downstream consumer of the SAP-1 output register: converts its 8-bit value to 3 decimal digits.
//  Conversion is sequential (shift-add-3, one bit per clk).
//  Drives a multiplexed, common-anode 3-digit 7-segment display.
//  Sits between the output register (o, load) and the board display pins.
// PARAMETERS
//  REFRESH_DIV  1000  clk cycles each digit stays lit before the scan advances (min 2)
//  CNT_W        10    width of the refresh counter; must satisfy 2**CNT_W >= REFRESH_DIV
// PORTS
//  clk      in   1  system clock, rising edge
//  reset    in   1  asynchronous, active-low reset
//  o_value  in   8  unsigned value from the output register
//  update   in   1  1-cycle strobe, same cycle the output register loads; sampled with o_value
//  busy     out  1  high while a conversion is in progress
//  bcd      out  12 {hundreds,tens,ones} of the last completed conversion
//  seg      out  7  segments {g,f,e,d,c,b,a}, active-low
//  an       out  3  digit enables, active-low; an[0]=ones, an[2]=hundreds
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - Outputs: busy=0, bcd=12'h000, seg=7'h7F, an=3'b111.
//   - Internals: FSM=IDLE, pending=0, refresh cnt=0, digit idx=0.
//  FSM IDLE -> CONVERT -> DONE -> IDLE.
//   - IDLE: update=1 captures o_value into the shift reg, clears the scratch BCD, goes to CONVERT.
//   - CONVERT: 8 cycles. Each cycle, every BCD nibble >=5 gets +3, then {bcd,shift} shifts left by 1.
//   - DONE: 1 cycle. Writes scratch BCD to bcd. Goes to CONVERT if pending, else IDLE.
//  Latency and busy:
//   - Strobe at cycle N: busy=1 on N+1..N+8; bcd valid from N+10; busy=0 on N+9.
//   - busy is a registered output, high only in CONVERT.
//  update while busy/DONE:
//   - Latch o_value into a pending buffer and set pending.
//   - Later strobes overwrite the buffer (newest wins).
//   - DONE reloads the shift reg from the buffer and clears pending.
//  update in IDLE: always starts a conversion, even if o_value is unchanged.
//  bcd never shows partial results; it changes only in DONE.
//  Scan:
//   - cnt counts 0..REFRESH_DIV-1; on wrap, idx steps 0->1->2->0.
//   - an and seg are registered: one cycle after reset release, an=3'b110 with seg = ones digit.
//  Digit decode (active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex).
//   - Any nibble >9 is impossible; it decodes to 7'h7F.
//  Reset mid-conversion aborts it: pending is lost and the previous bcd is cleared to 0.
// CONFIGURATION
//  OUTDISP_LZB_EN defined: leading-zero blanking.
//   - hundreds==0 blanks the hundreds digit (seg=7'h7F while selected).
//   - hundreds==0 && tens==0 also blanks the tens digit.
//   - ones is never blanked. an scanning is unchanged.
//  Undefined: all three digits are always shown (value 7 displays "007").
// STRUCTURE
//  Shared package sap1_display_pkg:
//   - SEG_0..SEG_9 and SEG_BLANK constants.
//   - FSM state encoding (IDLE=2'd0, CONVERT=2'd1, DONE=2'd2).
//  Sub-module seg7_decoder: combinational 4-bit BCD -> 7-bit active-low segments.
//  Top module: FSM, shift/BCD datapath, pending buffer, refresh counter, output regs.
// TESTING (bench uses REFRESH_DIV=4)
//  1 Reset held low: busy=0, bcd=000, an=111, seg=7F.
//    After release: an=110, then 101, 011, cycling every 4 clks.
//  2 update with o_value=8'd15:
//    busy high exactly 8 cycles, bcd=12'h015.
//    Scan shows ones seg=12, tens seg=79, hundreds seg=40 (no LZB).
//  3 o_value=8'd255 -> bcd=12'h255; o_value=8'd0 -> bcd=12'h000.
//    Every seg/an pair checked over one full scan.
//  4 Strobe 8'd123, then strobes 8'd77 and 8'd200 while busy:
//    bcd=123 first, then exactly one more conversion, final bcd=12'h200.
//  5 Assert reset in the 4th CONVERT cycle of 8'd99:
//    busy/bcd/an/seg return to reset values immediately; no stale result appears afterwards.
//  6 OUTDISP_LZB_EN defined, o_value=8'd7: hundreds/tens slots seg=7F, ones seg=78.
//    With 8'd105, tens shows 40. Macro undefined: 8'd7 shows 40,40,78.

Source files
------------

// File: rtl/output_display_driver_pkg.sv
// Shared display constants, FSM encoding and the shift-add-3 nibble helper
// used by the SAP-1 output display driver.
package sap1_display_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } disp_state_e;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int unsigned CONV_BITS = 8;

  // Each BCD nibble >= 5 gets +3 so the following left shift carries correctly.
  function automatic logic [11:0] add3_bcd(input logic [11:0] b);
    logic [11:0] r;
    for (int i = 0; i < 3; i++) begin
      r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? (b[i*4 +: 4] + 4'd3) : b[i*4 +: 4];
    end
    return r;
  endfunction

endpackage

// File: rtl/output_display_driver_if.sv
// Bus between the output register side (value/strobe) and the display driver
// outputs (busy, converted BCD, segment and anode pins).
interface output_display_driver_if;
  logic [7:0]  o_value;
  logic        update;
  logic        busy;
  logic [11:0] bcd;
  logic [6:0]  seg;
  logic [2:0]  an;

  modport master (output o_value, update, input busy, bcd, seg, an);
  modport slave  (input o_value, update, output busy, bcd, seg, an);
endinterface

// File: rtl/output_display_driver_seg7_decoder.sv
// Combinational 4-bit BCD digit to active-low {g,f,e,d,c,b,a} segments.
module seg7_decoder
  import sap1_display_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/output_display_driver.sv
// 8-bit value to 3-digit BCD (serial shift-add-3) with multiplexed common-anode
// 7-segment scan. Optional leading-zero blanking: define OUTDISP_LZB_EN.
//
// state   | meaning
// IDLE    | waiting for an update strobe
// CONVERT | 8 shift-add-3 steps, busy high
// DONE    | publish scratch BCD, restart if a newer value is pending
module output_display_driver
  import sap1_display_pkg::*;
#(
  parameter int REFRESH_DIV = 1000,
  parameter int CNT_W       = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  output_display_driver_if.slave  bus
);

  disp_state_e r_state, w_state_nxt;
  logic        w_load_new, w_load_pend, w_shift_en, w_done;

  logic [7:0]  r_shift;
  logic [11:0] r_scratch;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_pend_buf;
  logic        r_pending;
  logic [11:0] r_bcd;
  logic        r_busy;

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [3:0]       w_nibble;
  logic [6:0]       w_seg_dec;
  logic             w_blank;
  logic [6:0]       r_seg;
  logic [2:0]       r_an;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_new  = 1'b0;
    w_load_pend = 1'b0;
    w_shift_en  = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.update) begin
          w_load_new  = 1'b1;
          w_state_nxt = CONVERT;
        end
      end
      CONVERT: begin
        w_shift_en = 1'b1;
        if (r_bit_cnt == 3'd0) w_state_nxt = DONE;
      end
      DONE: begin
        w_done = 1'b1;
        // A strobe landing in DONE is the newest value and supersedes the buffer.
        if (bus.update) begin
          w_load_new  = 1'b1;
          w_state_nxt = CONVERT;
        end else if (r_pending) begin
          w_load_pend = 1'b1;
          w_state_nxt = CONVERT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift   <= '0;
      r_scratch <= '0;
      r_bit_cnt <= '0;
      r_bcd     <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == CONVERT);
      if (w_done) r_bcd <= r_scratch;
      if (w_load_new || w_load_pend) begin
        r_shift   <= w_load_new ? bus.o_value : r_pend_buf;
        r_scratch <= '0;
        r_bit_cnt <= 3'(CONV_BITS - 1);
      end else if (w_shift_en) begin
        {r_scratch, r_shift} <= {add3_bcd(r_scratch), r_shift} << 1;
        if (r_bit_cnt != 3'd0) r_bit_cnt <= r_bit_cnt - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend_buf <= '0;
      r_pending  <= 1'b0;
    end else if (w_load_new || w_load_pend) begin
      r_pending <= 1'b0;
    end else if (bus.update && r_state == CONVERT) begin
      r_pend_buf <= bus.o_value;
      r_pending  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (r_cnt == CNT_W'(REFRESH_DIV - 1)) begin
      r_cnt <= '0;
      r_idx <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_nibble = 4'd0;
    case (r_idx)
      2'd0:    w_nibble = r_bcd[3:0];
      2'd1:    w_nibble = r_bcd[7:4];
      2'd2:    w_nibble = r_bcd[11:8];
      default: w_nibble = 4'd0;
    endcase
  end

  seg7_decoder u_seg7_decoder (
    .i_bcd (w_nibble),
    .o_seg (w_seg_dec)
  );

`ifdef OUTDISP_LZB_EN
  assign w_blank = ((r_idx == 2'd2) && (r_bcd[11:8] == 4'd0)) ||
                   ((r_idx == 2'd1) && (r_bcd[11:8] == 4'd0) && (r_bcd[7:4] == 4'd0));
`else
  assign w_blank = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_seg <= SEG_BLANK;
      r_an  <= 3'b111;
    end else begin
      r_seg <= w_blank ? SEG_BLANK : w_seg_dec;
      case (r_idx)
        2'd0:    r_an <= 3'b110;
        2'd1:    r_an <= 3'b101;
        2'd2:    r_an <= 3'b011;
        default: r_an <= 3'b111;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.bcd  = r_bcd;
  assign bus.seg  = r_seg;
  assign bus.an   = r_an;

endmodule

// File: tb/tb_output_display_driver.sv
// Directed bench for output_display_driver with REFRESH_DIV=4; expected values
// are hand-computed. Build with OUTDISP_LZB_EN to exercise leading-zero blanking.
module tb_output_display_driver;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  output_display_driver_if dif ();

  output_display_driver #(
    .REFRESH_DIV (4),
    .CNT_W       (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe v in, expect exactly 8 busy cycles, bcd held during DONE, then exp_bcd.
  task automatic convert(input logic [7:0] v, input logic [11:0] exp_bcd,
                         input logic [11:0] prev_bcd);
    int n;
    dif.o_value = v;
    dif.update  = 1'b1;
    tick();
    dif.update  = 1'b0;
    n = 0;
    while (dif.busy === 1'b1 && n < 50) begin
      n++;
      tick();
    end
    chk("busy_cycles", 32'(n), 32'd8);
    chk("bcd_hold_done", 32'(dif.bcd), 32'(prev_bcd));
    tick();
    chk("bcd_result", 32'(dif.bcd), 32'(exp_bcd));
    tick();
  endtask

  task automatic scan(input logic [6:0] e_ones, input logic [6:0] e_tens,
                      input logic [6:0] e_hund);
    for (int k = 0; k < 12; k++) begin
      tick();
      case (dif.an)
        3'b110:  chk("seg_ones", 32'(dif.seg), 32'(e_ones));
        3'b101:  chk("seg_tens", 32'(dif.seg), 32'(e_tens));
        3'b011:  chk("seg_hund", 32'(dif.seg), 32'(e_hund));
        default: chk("an_onehot", 32'(dif.an), 32'h6);
      endcase
    end
  endtask

  initial begin
    logic [2:0] an_exp;
    int n;
    n_checks    = 0;
    n_errors    = 0;
    reset       = 1'b0;
    dif.update  = 1'b0;
    dif.o_value = 8'd0;

    #23;
    chk("rst_busy", 32'(dif.busy), 32'd0);
    chk("rst_bcd",  32'(dif.bcd),  32'h000);
    chk("rst_an",   32'(dif.an),   32'h7);
    chk("rst_seg",  32'(dif.seg),  32'h7F);

    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      case ((k / 4) % 3)
        0:       an_exp = 3'b110;
        1:       an_exp = 3'b101;
        default: an_exp = 3'b011;
      endcase
      chk("scan_an", 32'(dif.an), 32'(an_exp));
    end

    convert(8'd15, 12'h015, 12'h000);
`ifdef OUTDISP_LZB_EN
    scan(7'h12, 7'h79, 7'h7F);
`else
    scan(7'h12, 7'h79, 7'h40);
`endif

    convert(8'd255, 12'h255, 12'h015);
    scan(7'h12, 7'h12, 7'h24);
    convert(8'd0, 12'h000, 12'h255);
`ifdef OUTDISP_LZB_EN
    scan(7'h40, 7'h7F, 7'h7F);
`else
    scan(7'h40, 7'h40, 7'h40);
`endif

    // 123 starts; 77 then 200 arrive while busy, only 200 should follow.
    dif.o_value = 8'd123;
    dif.update  = 1'b1;
    tick();
    dif.update  = 1'b0;
    tick();
    dif.o_value = 8'd77;
    dif.update  = 1'b1;
    tick();
    dif.update  = 1'b0;
    tick();
    dif.o_value = 8'd200;
    dif.update  = 1'b1;
    tick();
    dif.update  = 1'b0;
    n = 0;
    while (dif.busy === 1'b1 && n < 50) begin
      n++;
      tick();
    end
    chk("pend_first_busy_end", 32'(n), 32'd4);
    chk("pend_hold_done", 32'(dif.bcd), 32'h000);
    tick();
    chk("pend_bcd_first", 32'(dif.bcd), 32'h123);
    chk("pend_rebusy", 32'(dif.busy), 32'd1);
    n = 0;
    while (dif.busy === 1'b1 && n < 50) begin
      n++;
      tick();
    end
    chk("pend_busy_cycles", 32'(n), 32'd8);
    tick();
    chk("pend_bcd_final", 32'(dif.bcd), 32'h200);
    repeat (20) tick();
    chk("pend_single_extra", 32'(dif.busy), 32'd0);
    chk("pend_bcd_stable", 32'(dif.bcd), 32'h200);

    convert(8'd7, 12'h007, 12'h200);
`ifdef OUTDISP_LZB_EN
    scan(7'h78, 7'h7F, 7'h7F);
`else
    scan(7'h78, 7'h40, 7'h40);
`endif
    convert(8'd105, 12'h105, 12'h007);
    scan(7'h12, 7'h40, 7'h79);
    convert(8'd105, 12'h105, 12'h105);

    // Abort 99 in its 4th CONVERT cycle.
    dif.o_value = 8'd99;
    dif.update  = 1'b1;
    tick();
    dif.update  = 1'b0;
    chk("abort_busy_pre", 32'(dif.busy), 32'd1);
    repeat (3) tick();
    #2;
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(dif.busy), 32'd0);
    chk("abort_bcd",  32'(dif.bcd),  32'h000);
    chk("abort_an",   32'(dif.an),   32'h7);
    chk("abort_seg",  32'(dif.seg),  32'h7F);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("abort_an_release", 32'(dif.an), 32'h6);
    repeat (30) tick();
    chk("abort_no_busy", 32'(dif.busy), 32'd0);
    chk("abort_no_stale", 32'(dif.bcd), 32'h000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
